// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header size and FSM state encoding for the UART packet ALU.
package uart_alu_pkg;

   localparam logic [7:0] OPC_ECHO  = 8'hEC;
   localparam logic [7:0] OPC_ADD   = 8'hAD;
   localparam logic [7:0] OPC_MUL   = 8'h11;
   localparam int         HDR_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      RSVD,
      LEN_L,
      LEN_H,
      PAYLOAD,
      MULT,
      TX,
      DRAIN
   } state_t;

endpackage

// File: rtl/uart_alu_mul_seq.sv
// Iterative shift-add multiplier, truncated to DATA_W bits; fixed DATA_W-cycle latency.
// done is combinational in the final iteration cycle, with p already holding the finished product.
module uart_alu_mul_seq #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] p
);
   localparam int CW = $clog2(DATA_W) + 1;

   logic              running;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] p_q;

   // p is the partial product after this cycle's multiplier bit is consumed
   assign p    = p_q + (b_q[0] ? a_q : '0);
   assign done = running && (cnt == CW'(DATA_W - 1));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         running <= 1'b0;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         a_q     <= a;
         b_q     <= b;
         p_q     <= '0;
      end else if (running) begin
         p_q <= p;
         a_q <= a_q << 1;
         b_q <= b_q >> 1;
         cnt <= cnt + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_alu_engine.sv
// Packet ALU between UART RX and TX byte streams: echo, multi-operand add and multiply.
// Echo is zero-latency passthrough; RX is stalled while multiplying and while the result drains to TX.
module uart_alu_engine
   import uart_alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       valid_o,
   output logic [7:0] data_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       err_o
);
   localparam int K  = DATA_W / 8;
   localparam int BW = (K > 1) ? $clog2(K) : 1;

   state_t            state, state_nx;
   logic [7:0]        opcode;
   logic [7:0]        len_lo;
   logic [15:0]       plen;
   logic [15:0]       pcnt;
   logic [BW-1:0]     bcnt;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W-1:0] acc;
   logic              first;
   logic              err_q;

   logic              in_fire;
   logic              is_echo, is_add, is_mul, is_arith;
   logic              len_bad, fmt_bad;
   logic              last_byte, op_done;
   logic [15:0]       len_full, plen_full;
   logic [DATA_W-1:0] opnd_nx;
   logic [7:0]        tx_byte;
   logic              mul_start, mul_done;
   logic [DATA_W-1:0] mul_p;

   assign is_echo   = (opcode == OPC_ECHO);
   assign is_add    = (opcode == OPC_ADD);
   assign is_mul    = MUL_EN && (opcode == OPC_MUL);
   assign is_arith  = is_add || is_mul;
   assign len_full  = {data_i, len_lo};
   assign plen_full = len_full - 16'(HDR_BYTES);
   assign len_bad   = (len_full < 16'(HDR_BYTES));
   assign fmt_bad   = is_arith && ((plen_full == 16'd0) || ((plen_full % 16'(K)) != 16'd0));
   assign last_byte = (pcnt == plen - 16'd1);
   assign op_done   = (bcnt == BW'(K - 1));
   // Operand bytes arrive LSB first, so shift each new byte in from the top
   assign opnd_nx   = (opnd >> 8) | (DATA_W'(data_i) << (DATA_W - 8));
   assign tx_byte   = 8'(acc >> {bcnt, 3'b000});
   assign in_fire   = valid_i && ready_o;
   assign busy_o    = (state != IDLE);
   assign err_o     = err_q;

   uart_alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .start    (mul_start),
      .a        (acc),
      .b        (opnd_nx),
      .done     (mul_done),
      .p        (mul_p)
   );

   always_comb begin
      state_nx  = state;
      ready_o   = 1'b1;
      valid_o   = 1'b0;
      data_o    = 8'h00;
      mul_start = 1'b0;
      case (state)
         IDLE:  if (valid_i) state_nx = RSVD;
         RSVD:  if (valid_i) state_nx = LEN_L;
         LEN_L: if (valid_i) state_nx = LEN_H;
         LEN_H: begin
            if (valid_i) begin
               if (len_bad)                 state_nx = IDLE;
               else if (fmt_bad)            state_nx = (plen_full == 16'd0) ? IDLE : DRAIN;
               else if (plen_full == 16'd0) state_nx = IDLE;
               else if (is_echo || is_arith) state_nx = PAYLOAD;
               else                         state_nx = DRAIN;
            end
         end
         PAYLOAD: begin
            if (is_echo) begin
               ready_o = ready_i;
               valid_o = valid_i;
               data_o  = data_i;
               if (valid_i && ready_i && last_byte) state_nx = IDLE;
            end else if (valid_i && op_done) begin
               if (!first && is_mul) begin
                  mul_start = 1'b1;
                  state_nx  = MULT;
               end else if (last_byte) begin
                  state_nx = TX;
               end
            end
         end
         MULT: begin
            ready_o = 1'b0;
            if (mul_done) state_nx = (pcnt == plen) ? TX : PAYLOAD;
         end
         TX: begin
            ready_o = 1'b0;
            valid_o = 1'b1;
            data_o  = tx_byte;
            if (ready_i && op_done) state_nx = IDLE;
         end
         DRAIN:   if (valid_i && last_byte) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state  <= IDLE;
         opcode <= 8'h00;
         len_lo <= 8'h00;
         plen   <= 16'd0;
         pcnt   <= 16'd0;
         bcnt   <= '0;
         opnd   <= '0;
         acc    <= '0;
         first  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  opcode <= data_i;
                  pcnt   <= 16'd0;
                  bcnt   <= '0;
                  first  <= 1'b1;
               end
            end
            LEN_L: if (valid_i) len_lo <= data_i;
            LEN_H: begin
               if (valid_i) begin
                  plen  <= plen_full;
                  err_q <= len_bad || fmt_bad;
               end
            end
            PAYLOAD: begin
               if (in_fire) begin
                  pcnt <= pcnt + 16'd1;
                  if (!is_echo) begin
                     opnd <= opnd_nx;
                     bcnt <= op_done ? '0 : bcnt + 1'b1;
                     if (op_done) begin
                        first <= 1'b0;
                        if (first)       acc <= opnd_nx;
                        else if (is_add) acc <= acc + opnd_nx;
                     end
                  end
               end
            end
            MULT: if (mul_done) acc <= mul_p;
            TX:   if (ready_i) bcnt <= op_done ? '0 : bcnt + 1'b1;
            DRAIN: if (valid_i) pcnt <= pcnt + 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_engine.sv
// Randomised and directed bench for uart_alu_engine (DATA_W = 32, MUL_EN = 1) against a packet-level model.
module tb_uart_alu_engine;

   logic       clk_i = 1'b0;
   logic       reset_ni = 1'b0;
   logic       valid_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       ready_o;
   logic       valid_o;
   logic [7:0] data_o;
   logic       ready_i = 1'b0;
   logic       busy_o;
   logic       err_o;

   uart_alu_engine #(.DATA_W(32), .MUL_EN(1'b1)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (valid_i),
      .data_i   (data_i),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .data_o   (data_o),
      .ready_i  (ready_i),
      .busy_o   (busy_o),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned got[$];
   byte unsigned exp_q[$];
   byte unsigned gen_q[$];
   int           low_runs[$];
   int           exp_errs, err_seen, stab_bad, echo_same, vr_both;
   bit           timed_out;

   // Packet-level reference: what the TX stream should carry and whether err_o should pulse
   function automatic void model(input byte unsigned pkt[$]);
      int len, p;
      longint unsigned r, x;
      len = int'({pkt[3], pkt[2]});
      if (len < 4) begin exp_errs++; return; end
      p = len - 4;
      if (pkt[0] == 8'hAD || pkt[0] == 8'h11) begin
         if (p == 0 || (p % 4) != 0) begin exp_errs++; return; end
         r = 0;
         for (int i = 0; i < p / 4; i++) begin
            x = 0;
            for (int j = 0; j < 4; j++) x = x + (longint'(pkt[4 + 4*i + j]) << (8*j));
            if (i == 0)               r = x;
            else if (pkt[0] == 8'hAD) r = (r + x) % 64'h1_0000_0000;
            else                      r = (r * x) % 64'h1_0000_0000;
         end
         for (int j = 0; j < 4; j++) exp_q.push_back(8'((r >> (8*j)) & 64'hFF));
      end else if (pkt[0] == 8'hEC) begin
         for (int i = 0; i < p; i++) exp_q.push_back(pkt[4 + i]);
      end
   endfunction

   function automatic logic [31:0] pack4();
      logic [31:0] w = 32'h0;
      for (int j = 0; j < 4; j++) if (j < got.size()) w[8*j +: 8] = got[j];
      return w;
   endfunction

   // Streams pkt into the DUT and records everything observed at the TX side.
   // Called and returns just after a rising edge; mode 0: ready_i=1, 1: toggle, else random.
   task automatic drive(input byte unsigned pkt[$], input int mode, input int max_cyc);
      int idx = 0, run = 0, ncyc = 0;
      bit stalled = 0, done = 0, in_fire, out_fire;
      logic [7:0] held = 8'h00;
      got.delete(); low_runs.delete();
      err_seen = 0; stab_bad = 0; echo_same = 0; vr_both = 0; timed_out = 0;
      valid_i = (pkt.size() > 0);
      data_i  = (pkt.size() > 0) ? pkt[0] : 8'h00;
      ready_i = (mode == 0);
      while (!done) begin
         @(negedge clk_i);
         if (err_o) err_seen++;
         if (stalled && valid_o && data_o !== held) stab_bad++;
         in_fire  = valid_i && ready_o;
         out_fire = valid_o && ready_i;
         if (out_fire) got.push_back(data_o);
         if (out_fire && in_fire && data_o == data_i) echo_same++;
         if (valid_o && ready_o) vr_both++;
         stalled = valid_o && !ready_i;
         held    = data_o;
         if (!ready_o) run++;
         else if (run > 0) begin low_runs.push_back(run); run = 0; end
         if (idx == pkt.size() && !busy_o) done = 1;
         else if (ncyc >= max_cyc) begin timed_out = 1; done = 1; end
         @(posedge clk_i); #1;
         if (in_fire) idx++;
         valid_i = (idx < pkt.size()) && !done;
         data_i  = 8'h00;
         if (valid_i) data_i = pkt[idx];
         case (mode)
            0:       ready_i = 1'b1;
            1:       ready_i = !ready_i;
            default: ready_i = 1'($urandom_range(0, 1));
         endcase
         ncyc++;
      end
   endtask

   task automatic test_reset();
      #3;
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o got=%b want=1", ready_o); end
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o got=%b want=0", valid_o); end
      n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data_o got=%h want=00", data_o); end
      n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err_o got=%b want=0", err_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_o got=%b want=0", busy_o); end
      #20 reset_ni = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_echo();
      drive('{8'hEC, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC}, 0, 100);
      n_checks++; if (got.size() != 3 || pack4() !== 32'h00CCBBAA) begin
         n_fail++; $display("FAIL echo_data got=%0d bytes %h want=3 bytes 00ccbbaa", got.size(), pack4()); end
      n_checks++; if (echo_same != 3) begin n_fail++; $display("FAIL echo_same_cycle got=%0d want=3", echo_same); end
      n_checks++; if (err_seen != 0 || timed_out) begin
         n_fail++; $display("FAIL echo_err got=%0d timeout=%b want=0", err_seen, timed_out); end
   endtask

   task automatic test_add_wrap();
      drive('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 100);
      n_checks++; if (got.size() != 4 || pack4() !== 32'h0) begin
         n_fail++; $display("FAIL add_wrap got=%0d bytes %h want=4 bytes 00000000", got.size(), pack4()); end
      n_checks++; if (busy_o !== 1'b0 || timed_out) begin
         n_fail++; $display("FAIL add_idle busy=%b timeout=%b want=0", busy_o, timed_out); end
   endtask

   task automatic test_mul();
      drive('{8'h11, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00}, 0, 300);
      n_checks++; if (got.size() != 4 || pack4() !== 32'h00000069) begin
         n_fail++; $display("FAIL mul_data got=%0d bytes %h want=4 bytes 00000069", got.size(), pack4()); end
      // 32 stall cycles per multiply; the last one runs straight into 4 TX cycles
      n_checks++; if (low_runs.size() != 2 || low_runs[0] != 32 || low_runs[1] != 36) begin
         n_fail++; $display("FAIL mul_stall got=%0d runs [%0d,%0d] want=2 runs [32,36]",
                            low_runs.size(), low_runs[0], low_runs[1]); end
   endtask

   task automatic test_tx_backpressure();
      drive('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 200);
      n_checks++; if (got.size() != 4 || pack4() !== 32'h01020304) begin
         n_fail++; $display("FAIL bp_data got=%0d bytes %h want=4 bytes 01020304", got.size(), pack4()); end
      n_checks++; if (stab_bad != 0) begin n_fail++; $display("FAIL bp_stable got=%0d changes want=0", stab_bad); end
      n_checks++; if (vr_both != 0 || low_runs.size() != 1 || low_runs[0] < 5) begin
         n_fail++; $display("FAIL bp_ready got=overlap %0d runs %0d first %0d want=overlap 0 runs 1 first>=5",
                            vr_both, low_runs.size(), low_runs[0]); end
   endtask

   task automatic test_malformed();
      drive('{8'hAD, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22}, 0, 100);
      n_checks++; if (err_seen != 1 || got.size() != 0 || timed_out) begin
         n_fail++; $display("FAIL bad_len_drain got=err %0d tx %0d want=err 1 tx 0", err_seen, got.size()); end
      drive('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A}, 0, 100);
      n_checks++; if (got.size() != 1 || got[0] !== 8'h5A || err_seen != 0) begin
         n_fail++; $display("FAIL echo_after_err got=%0d bytes %h err %0d want=1 byte 5a err 0",
                            got.size(), pack4(), err_seen); end
      drive('{8'h55, 8'h00, 8'h05, 8'h00, 8'h99}, 0, 100);
      n_checks++; if (err_seen != 0 || got.size() != 0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL unknown_drain got=err %0d tx %0d busy %b want=0 0 0", err_seen, got.size(), busy_o); end
      drive('{8'hAD, 8'h00, 8'h03, 8'h00}, 0, 100);
      n_checks++; if (err_seen != 1 || got.size() != 0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL short_len got=err %0d tx %0d busy %b want=1 0 0", err_seen, got.size(), busy_o); end
   endtask

   task automatic test_reset_mid_tx();
      byte unsigned pkt[$] = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                               8'h05, 8'h06, 8'h07, 8'h08};
      ready_i = 1'b0;
      foreach (pkt[i]) begin
         valid_i = 1'b1; data_i = pkt[i];
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; data_i = 8'h00;
      @(negedge clk_i);
      for (int c = 0; c < 5 && !valid_o; c++) @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h06) begin
         n_fail++; $display("FAIL tx_before_reset got=valid %b data %h want=1 06", valid_o, data_o); end
      #2 reset_ni = 1'b0;
      #1;
      n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00) begin
         n_fail++; $display("FAIL async_reset got=valid %b busy %b ready %b data %h want=0 0 1 00",
                            valid_o, busy_o, ready_o, data_o); end
      @(negedge clk_i) reset_ni = 1'b1;
      @(posedge clk_i); #1;
      drive('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h12, 8'h34}, 0, 100);
      n_checks++; if (got.size() != 2 || pack4() !== 32'h00003412) begin
         n_fail++; $display("FAIL after_reset got=%0d bytes %h want=2 bytes 00003412", got.size(), pack4()); end
   endtask

   // Back-to-back random packets in a single stream under random TX backpressure
   task automatic test_back_to_back();
      byte unsigned stream[$];
      int kind, p, bad_idx;
      exp_q.delete(); exp_errs = 0;
      for (int n = 0; n < 24; n++) begin
         kind = $urandom_range(0, 5);
         gen_q.delete();
         case (kind)
            0:       begin gen_q.push_back(8'hEC); p = $urandom_range(0, 6); end
            1:       begin gen_q.push_back(8'hAD); p = 4 * $urandom_range(1, 3); end
            2:       begin gen_q.push_back(8'h11); p = 4 * $urandom_range(1, 3); end
            3:       begin gen_q.push_back(8'h55); p = $urandom_range(0, 3); end
            4:       begin gen_q.push_back(8'hAD); p = $urandom_range(1, 3); end
            default: begin gen_q.push_back(8'($urandom)); p = -4 + $urandom_range(0, 3); end
         endcase
         gen_q.push_back(8'($urandom));
         gen_q.push_back(8'(p + 4));
         gen_q.push_back(8'h00);
         for (int i = 0; i < p; i++) gen_q.push_back(8'($urandom));
         model(gen_q);
         foreach (gen_q[i]) stream.push_back(gen_q[i]);
      end
      drive(stream, 2, 20000);
      bad_idx = -1;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         if (bad_idx < 0 && got[i] !== exp_q[i]) bad_idx = i;
      n_checks++; if (got.size() != exp_q.size() || bad_idx >= 0 || timed_out) begin
         n_fail++; $display("FAIL stream_data got=%0d bytes (first diff %0d) want=%0d bytes timeout=%b",
                            got.size(), bad_idx, exp_q.size(), timed_out); end
      n_checks++; if (err_seen != exp_errs) begin
         n_fail++; $display("FAIL stream_err got=%0d want=%0d", err_seen, exp_errs); end
      n_checks++; if (stab_bad != 0) begin n_fail++; $display("FAIL stream_stable got=%0d want=0", stab_bad); end
   endtask

   initial begin
      test_reset();
      test_echo();
      test_add_wrap();
      test_mul();
      test_tx_backpressure();
      test_malformed();
      test_reset_mid_tx();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
